// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared widths, state encoding and helpers for the matrix datapath.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_N = 3;

    // Accumulator width carried by the upstream matrix stage for element width w.
    function automatic int acc_w(input int w);
        return 3 * w;
    endfunction

    localparam int ACC_W = acc_w(DEF_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/act_requant_if.sv
`default_nettype none
// ============================================================================
// Module   : act_requant_if
// Brief    : Upstream capture and downstream vector handshake for act_requant.
// Revision : 1.0 - initial release
// ============================================================================
interface act_requant_if #(
    parameter int W = matrix_pkg::DEF_W,
    parameter int N = matrix_pkg::DEF_N
);
    localparam int AW = 3 * W;

    logic                 start;
    logic signed [AW-1:0] y [N];
    logic [4:0]           shift;
    logic                 relu_en;
    logic signed [W-1:0]  x_out [N];
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 sat;
    logic                 overrun;

    modport master (
        output start, y, shift, relu_en, out_ready,
        input  x_out, out_valid, busy, sat, overrun
    );

    modport slave (
        input  start, y, shift, relu_en, out_ready,
        output x_out, out_valid, busy, sat, overrun
    );
endinterface
`default_nettype wire

// File: rtl/requant_unit.sv
`default_nettype none
// ============================================================================
// Module   : requant_unit
// Brief    : One-element relu, round-half-up, arithmetic shift and saturate.
// Revision : 1.0 - initial release
// ============================================================================
module requant_unit
    import matrix_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  wire logic signed [3*W-1:0] i_y,
    input  wire logic [4:0]            i_shift,
    input  wire logic                  i_relu_en,
    output logic signed [W-1:0]        o_x,
    output logic                       o_sat
);
    localparam int AW = acc_w(W);
    localparam logic signed [AW:0] C_ONE = (AW+1)'(1);
    localparam logic signed [AW:0] C_MAX = {{(AW-W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW:0] C_MIN = {{(AW-W+2){1'b1}}, {(W-1){1'b0}}};

    // One guard bit above the accumulator so the rounding add cannot wrap.
    logic signed [AW:0] w_relu;
    logic signed [AW:0] w_rnd;
    logic signed [AW:0] w_sum;
    logic signed [AW:0] w_shr;

    always_comb begin
        w_relu = (i_relu_en && i_y[AW-1]) ? '0 : {i_y[AW-1], i_y};
        w_rnd  = '0;
        if (i_shift != 5'd0) begin
            w_rnd = C_ONE <<< (i_shift - 5'd1);
        end
        w_sum = w_relu + w_rnd;
        w_shr = w_sum >>> i_shift;
        o_x   = w_shr[W-1:0];
        o_sat = 1'b0;
        if (w_shr > C_MAX) begin
            o_x   = C_MAX[W-1:0];
            o_sat = 1'b1;
        end else if (w_shr < C_MIN) begin
            o_x   = C_MIN[W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/act_requant.sv
`default_nettype none
// ============================================================================
// Module   : act_requant
// Brief    : Captures an accumulator vector and requantizes it one element per
//            cycle, then holds the W-bit result until downstream accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module act_requant
    import matrix_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  wire logic     clk,
    input  wire logic     reset,
    act_requant_if.slave  bus
);
    localparam int            AW     = acc_w(W);
    localparam int            IW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] C_LAST = IW'(N - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 start_prev_q, start_prev_d;
    logic signed [AW-1:0] y_q [N];
    logic signed [AW-1:0] y_d [N];
    logic [4:0]           shift_q, shift_d;
    logic                 relu_q, relu_d;
    logic signed [W-1:0]  x_q [N];
    logic signed [W-1:0]  x_d [N];
    logic                 sat_q, sat_d;
    logic                 ovr_q, ovr_d;

    logic signed [W-1:0]  w_rq_x;
    logic                 w_rq_sat;
    logic                 w_start_edge;

    requant_unit #(.W(W)) u_requant (
        .i_y       (y_q[idx_q]),
        .i_shift   (shift_q),
        .i_relu_en (relu_q),
        .o_x       (w_rq_x),
        .o_sat     (w_rq_sat)
    );

    assign w_start_edge = bus.start & ~start_prev_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        start_prev_d = bus.start;
        y_d          = y_q;
        shift_d      = shift_q;
        relu_d       = relu_q;
        x_d          = x_q;
        sat_d        = sat_q;
        ovr_d        = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start_edge) begin
                    y_d     = bus.y;
                    shift_d = bus.shift;
                    relu_d  = bus.relu_en;
                    sat_d   = 1'b0;
                    ovr_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_PROC;
                end
            end
            ST_PROC: begin
                x_d[idx_q] = w_rq_x;
                sat_d      = sat_q | w_rq_sat;
                ovr_d      = ovr_q | w_start_edge;
                if (idx_q == C_LAST) begin
                    idx_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // An edge coinciding with the accept is dropped, not queued.
                ovr_d = ovr_q | w_start_edge;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            start_prev_q <= 1'b0;
            y_q          <= '{default: '0};
            shift_q      <= '0;
            relu_q       <= 1'b0;
            x_q          <= '{default: '0};
            sat_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            start_prev_q <= start_prev_d;
            y_q          <= y_d;
            shift_q      <= shift_d;
            relu_q       <= relu_d;
            x_q          <= x_d;
            sat_q        <= sat_d;
            ovr_q        <= ovr_d;
        end
    end

    assign bus.x_out     = x_q;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sat       = sat_q;
    assign bus.overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_act_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_requant
// Brief    : Directed self-checking bench for act_requant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_requant;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int AW = 3 * W;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    act_requant_if #(.W(W), .N(N)) bus ();

    act_requant #(.W(W), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse, scrambles y afterwards, waits for out_valid.
    task automatic launch(input int a0, input int a1, input int a2,
                          input logic [4:0] sh, input logic rl, output int lat);
        bus.y[0]    = AW'(a0);
        bus.y[1]    = AW'(a1);
        bus.y[2]    = AW'(a2);
        bus.shift   = sh;
        bus.relu_en = rl;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        for (int i = 0; i < N; i++) bus.y[i] = AW'(12345 + 1000 * i);
        bus.shift   = 5'd7;
        bus.relu_en = ~rl;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sat !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got valid=%b busy=%b sat=%b ovr=%b want 0000",
                     bus.out_valid, bus.busy, bus.sat, bus.overrun);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_x_out[%0d] got %0d want 0", i, bus.x_out[i]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        int exp [N];
        exp = '{0, 2, 2};
        launch(0, 2, 2, 5'd0, 1'b1, lat);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 3", lat);
        end
        n_tests++;
        if (bus.busy !== 1'b1 || bus.sat !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags got busy=%b sat=%b ovr=%b want 100", bus.busy, bus.sat, bus.overrun);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp[i]);
            end
        end
        accept();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release got valid=%b busy=%b want 00", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_saturate();
        int lat;
        int exp [N];
        exp = '{127, -128, 127};
        launch(300, -300, 127, 5'd0, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || bus.sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_flag got lat=%0d sat=%b want lat=3 sat=1", lat, bus.sat);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL sat_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp[i]);
            end
        end
        accept();
    endtask

    task automatic test_round();
        int lat;
        int exp [N];
        exp = '{1, 2, -1};
        launch(5, 6, -6, 5'd2, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || bus.sat !== 1'b0) begin
            n_fail++;
            $display("FAIL round_flag got lat=%0d sat=%b want lat=3 sat=0", lat, bus.sat);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL round_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp[i]);
            end
        end
        accept();
    endtask

    task automatic test_relu_wide();
        int lat;
        int exp_r [N];
        int exp_w [N];
        exp_r = '{0, 50, 0};
        exp_w = '{1, -1, 0};
        launch(-5, 100, -1, 5'd1, 1'b1, lat);
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL relu_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp_r[i]);
            end
        end
        accept();
        // Extreme accumulators with the largest shift: rounding must not wrap.
        launch(8388607, -8388608, 0, 5'd23, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || bus.sat !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_flag got lat=%0d sat=%b want lat=3 sat=0", lat, bus.sat);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL wide_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp_w[i]);
            end
        end
        accept();
    endtask

    task automatic test_hold();
        int lat;
        int exp [N];
        logic seen_valid;
        exp = '{1, 2, -1};
        launch(5, 6, -6, 5'd2, 1'b0, lat);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL hold_latency got %0d want 3", lat);
        end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.x_out[0] !== exp[0] || bus.x_out[1] !== exp[1] || bus.x_out[2] !== exp[2]) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d got valid=%b x={%0d,%0d,%0d} want valid=1 x={1,2,-1}",
                         k, bus.out_valid, bus.x_out[0], bus.x_out[1], bus.x_out[2]);
            end
            bus.start = (k == 2);
            if (k == 2) for (int i = 0; i < N; i++) bus.y[i] = AW'(100);
            tick();
        end
        bus.start = 1'b0;
        n_tests++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_overrun got %b want 1", bus.overrun);
        end
        accept();
        seen_valid = 1'b0;
        repeat (5) begin
            tick();
            seen_valid |= bus.out_valid | bus.busy;
        end
        n_tests++;
        if (seen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_recapture got activity=%b want 0", seen_valid);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL idle_keep_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_proc();
        int lat;
        int exp [N];
        exp = '{-1, 64, -128};
        bus.y[0] = AW'(7);
        bus.y[1] = AW'(8);
        bus.y[2] = AW'(9);
        bus.shift = 5'd0;
        bus.relu_en = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sat !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags got busy=%b valid=%b sat=%b ovr=%b want 0000",
                     bus.busy, bus.out_valid, bus.sat, bus.overrun);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== '0) begin
                n_fail++;
                $display("FAIL abort_x_out[%0d] got %0d want 0", i, bus.x_out[i]);
            end
        end
        launch(-1, 64, -129, 5'd0, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || bus.sat !== 1'b1 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort_flags got lat=%0d sat=%b ovr=%b want lat=3 sat=1 ovr=0",
                     lat, bus.sat, bus.overrun);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL after_abort_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp[i]);
            end
        end
        accept();
    endtask

    task automatic test_start_held();
        int hs;
        int exp [N];
        exp = '{5, 10, 15};
        hs = 0;
        bus.y[0] = AW'(10);
        bus.y[1] = AW'(20);
        bus.y[2] = AW'(30);
        bus.shift = 5'd1;
        bus.relu_en = 1'b0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.out_valid && bus.out_ready) hs++;
        end
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.out_valid && bus.out_ready) hs++;
        end
        bus.out_ready = 1'b0;
        n_tests++;
        if (hs !== 1 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start got handshakes=%0d ovr=%b want 1 and 0", hs, bus.overrun);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (bus.x_out[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL held_x_out[%0d] got %0d want %0d", i, bus.x_out[i], exp[i]);
            end
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.shift     = 5'd0;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) bus.y[i] = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_round();
        test_relu_wide();
        test_hold();
        test_reset_mid_proc();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/act_requant.md
ACT_REQUANT -- requirements
Module: act_requant

Interface
REQ-001 Parameter W, default 8: element width of the outgoing vector; incoming accumulator width is 3*W.
REQ-002 Parameter N, default 3: vector length, equal to the row count of the upstream matrix stage.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  connected to the upstream matrix stage's done; sampled as a level, acted on at its rising edge.
REQ-006 y[0:N-1]  in  signed 3*W each  upstream accumulator outputs (W·x + b).
REQ-007 shift  in  5  arithmetic right-shift amount, legal range 0..3*W-1, sampled at capture.
REQ-008 relu_en  in  1  1 = clamp negatives to zero, sampled at capture.
REQ-009 x_out[0:N-1]  out  signed W each  requantized vector, ready to drive the next matrix stage's x.
REQ-010 out_valid  out  1  x_out holds a complete vector.
REQ-011 out_ready  in  1  downstream accepts the vector when high with out_valid.
REQ-012 busy  out  1  high in PROC and HOLD.
REQ-013 sat  out  1  at least one element of the current vector saturated.
REQ-014 overrun  out  1  start edge arrived while busy; sticky until next capture.

Function
REQ-015 FSM states IDLE, PROC, HOLD.
REQ-016 Start edge = start high this cycle, low in the previous cycle (registered start_d).
REQ-017 IDLE + start edge: capture all y, shift, relu_en into internal registers; clear sat, overrun, index; go to PROC.
REQ-018 PROC: process one element per cycle at index 0..N-1 and write x_out[index]; after index N-1, go to HOLD.
REQ-019 Latency: out_valid rises N cycles after the capture edge.
REQ-020 Per element, apply in order: relu (negative -> 0 if relu_en); add 2^(shift-1) when shift>0 (round half up); arithmetic shift right; saturate to [-2^(W-1), 2^(W-1)-1].
REQ-021 Rounding addition is performed in 3*W+1 bits; no intermediate wrap-around is permitted.
REQ-022 Any saturating element sets sat; sat holds until the next capture.
REQ-023 HOLD: out_valid=1; x_out and sat stable; leave for IDLE on the cycle where out_ready=1.
REQ-024 x_out keeps its last value in IDLE; out_valid=0 outside HOLD.
REQ-025 Start edge in PROC or HOLD: ignored (no recapture); overrun set.
REQ-026 Start held high after capture produces no second capture; a new edge is required.
REQ-027 Start edge in the same cycle HOLD exits: ignored (overrun set); upstream must re-pulse.
REQ-028 Upstream y may change after the capture edge without affecting the result.

Reset
REQ-029 Reset applies to state=IDLE, index=0, start_d=0, x_out all 0, out_valid=0, busy=0, sat=0, overrun=0.
REQ-030 Reset asserted in PROC or HOLD aborts the vector immediately; the partial result is discarded.

Structure
REQ-031 Shared package matrix_pkg: default W and N, ACC_W = 3*W, state enum type for IDLE/PROC/HOLD.
REQ-032 One combinational sub-module requant_unit (relu, round, shift, saturate, sat flag for one element) is instantiated once and multiplexed by index.

Verification
REQ-033 y={0,2,2}, shift=0, relu_en=1, start pulse -> x_out={0,2,2}; out_valid 3 cycles after capture; sat=0.
REQ-034 y={300,-300,127}, shift=0, relu_en=0 -> x_out={127,-128,127}; sat=1.
REQ-035 y={5,6,-6}, shift=2, relu_en=0 -> x_out={1,2,-1}.
REQ-036 out_ready low 5 cycles in HOLD -> out_valid and x_out stable throughout; start pulse during HOLD -> overrun=1 and no recapture.
REQ-037 Reset 1 cycle mid-PROC -> next cycle IDLE, all outputs 0; a new start yields a correct vector.
REQ-038 start held high 10 cycles -> exactly one capture and one out_valid handshake.
